// File: rtl/tdm_pkg.sv
// Shared types for the 4-slot TDM demultiplexer: FSM state, slot index and frame size.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_4ch.sv
// Splits a time-multiplexed beat stream into four channel registers, one frame at a time.
// Outputs change only when a complete frame has been collected.
//
// state   | meaning
// IDLE    | waiting for a frame_start beat; plain beats are ignored
// COLLECT | slots 0..slot_q-1 captured in shadow, waiting for slot slot_q
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_SLOTS = tdm_pkg::NUM_SLOTS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  state_t           state_q;
  slot_t            slot_q;
  slot_t            slot_d;
  logic [WIDTH-1:0] shadow_q [NUM_SLOTS-1];
  logic [WIDTH-1:0] out_q    [NUM_SLOTS];
  logic             frame_valid_q;
  logic             frame_error_q;

  always_comb begin
    slot_d = slot_q + slot_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++)     out_q[i]    <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          IDLE: begin
            if (frame_start) begin
              shadow_q[0] <= in_data;
              slot_q      <= slot_t'(1);
              state_q     <= COLLECT;
            end
          end
          COLLECT: begin
            if (frame_start) begin
              // abort the partial frame and restart on this beat as slot 0
              frame_error_q <= 1'b1;
              shadow_q[0]   <= in_data;
              slot_q        <= slot_t'(1);
            end else if (slot_q == LAST_SLOT) begin
              out_q[0]      <= shadow_q[0];
              out_q[1]      <= shadow_q[1];
              out_q[2]      <= shadow_q[2];
              out_q[3]      <= in_data;
              frame_valid_q <= 1'b1;
              slot_q        <= '0;
              state_q       <= IDLE;
            end else begin
              case (slot_q)
                2'd1:    shadow_q[1] <= in_data;
                2'd2:    shadow_q[2] <= in_data;
                default: shadow_q[0] <= in_data;
              endcase
              slot_q <= slot_d;
            end
          end
          default: begin
            state_q <= IDLE;
            slot_q  <= '0;
          end
        endcase
      end
    end
  end

  assign out_0       = out_q[0];
  assign out_1       = out_q[1];
  assign out_2       = out_q[2];
  assign out_3       = out_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: a reference model predicts each cycle and
// completed frames are queued and popped when frame_valid is expected.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] out_0, out_1, out_2, out_3;
  logic       frame_valid, frame_error, busy;

  tdm_demux_4ch #(.WIDTH(8), .NUM_SLOTS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .out_0       (out_0),
    .out_1       (out_1),
    .out_2       (out_2),
    .out_3       (out_3),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [31:0] sb [$];
  logic [31:0] last_exp = '0;
  logic [7:0]  m_sh [3];
  int          m_slot = 0;
  logic        m_busy = 1'b0;
  logic        exp_fv = 1'b0;
  logic        exp_fe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_cycle();
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
    chk("frame_error", {31'd0, frame_error}, {31'd0, exp_fe});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (exp_fv) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else last_exp = sb.pop_front();
    end
    chk("out_0", {24'd0, out_0}, {24'd0, last_exp[31:24]});
    chk("out_1", {24'd0, out_1}, {24'd0, last_exp[23:16]});
    chk("out_2", {24'd0, out_2}, {24'd0, last_exp[15:8]});
    chk("out_3", {24'd0, out_3}, {24'd0, last_exp[7:0]});
  endtask

  task automatic step(input logic v, input logic fs, input logic [7:0] d);
    @(negedge clk);
    in_valid = v; frame_start = fs; in_data = d;
    exp_fv = 1'b0; exp_fe = 1'b0;
    if (v) begin
      if (!m_busy) begin
        if (fs) begin m_sh[0] = d; m_slot = 1; m_busy = 1'b1; end
      end else if (fs) begin
        exp_fe = 1'b1; m_sh[0] = d; m_slot = 1;
      end else if (m_slot == 3) begin
        sb.push_back({m_sh[0], m_sh[1], m_sh[2], d});
        exp_fv = 1'b1; m_slot = 0; m_busy = 1'b0;
      end else begin
        m_sh[m_slot] = d; m_slot++;
      end
    end
    @(posedge clk); #1;
    check_cycle();
  endtask

  task automatic do_reset(input logic v, input logic fs, input logic [7:0] d);
    @(negedge clk);
    reset = 1'b1; in_valid = v; frame_start = fs; in_data = d;
    exp_fv = 1'b0; exp_fe = 1'b0;
    m_busy = 1'b0; m_slot = 0;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
    last_exp = '0;
    sb.delete();
    @(posedge clk); #1;
    check_cycle();
    reset = 1'b0;
  endtask

  task automatic frame(input logic [31:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), f[31-8*i -: 8]);
      if (i < 3) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'hFF);
    end
  endtask

  initial begin
    // reset state
    do_reset(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // contiguous frame
    frame(32'h11223344, 0);
    step(1'b0, 1'b0, 8'h00);

    // same frame with 3-cycle gaps
    frame(32'h11223344, 3);
    step(1'b0, 1'b0, 8'h00);
    frame(32'h5A6B7C8D, 3);
    step(1'b0, 1'b0, 8'h00);

    // abort after slot 1, restart frame
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    frame(32'hB1B2B3B4, 0);
    step(1'b0, 1'b0, 8'h00);

    // abort at slot 3
    step(1'b1, 1'b1, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    frame(32'hD1D2D3D4, 0);

    // back-to-back frames with no bubble
    frame(32'h01020304, 0);
    frame(32'h05060708, 0);
    step(1'b0, 1'b0, 8'h00);

    // reset mid-frame, with a competing frame_start beat during reset
    frame(32'h11223344, 0);
    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    do_reset(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b0, 8'h00);
    frame(32'h99AABBCC, 0);
    step(1'b0, 1'b0, 8'h00);

    // plain beats while idle are ignored
    step(1'b1, 1'b0, 8'hEE);
    step(1'b1, 1'b0, 8'hEE);
    step(1'b1, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 8'h00);

    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
